// File: rtl/i2s_rx_capture_if.sv
// Bus bundle for the I2S capture block: serial input, frame timing, captured samples
// and the host RAM read port.
interface i2s_rx_capture_if;
  logic        sd;
  logic        capture_en;
  logic        sck;
  logic        ws;
  logic [5:0]  frame_posn;
  logic [7:0]  frame;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample_valid;
  logic        re;
  logic [7:0]  raddr;
  logic [15:0] rdata;

  modport slave (
    input  sd, capture_en, re, raddr,
    output sck, ws, frame_posn, frame, left, right, sample_valid, rdata
  );

  modport master (
    output sd, capture_en, re, raddr,
    input  sck, ws, frame_posn, frame, left, right, sample_valid, rdata
  );
endinterface

// File: rtl/i2s_rx_capture.sv
// I2S receiver: generates sck/ws frame timing, deserialises 16-bit stereo samples and
// stores each pair in a 256x16 RAM that the host reads through a registered port.
module i2s_rx_capture #(
  parameter int SCK_DIV = 2
) (
  input logic             ck,
  input logic             rst,
  i2s_rx_capture_if.slave bus
);
  localparam int            PW          = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCK_DIV - 1);
  localparam logic [5:0]    LEFT_DONE   = 6'd16;
  localparam logic [5:0]    RIGHT_DONE  = 6'd48;

  logic [PW-1:0] presc_r;
  logic          sck_r;
  logic [5:0]    posn_r;
  logic [7:0]    frame_r;
  logic [15:0]   shift_r;
  logic [15:0]   left_r;
  logic [15:0]   right_r;
  logic          right_done_r;
  logic          sample_valid_r;
  logic          right_pend_r;
  logic [6:0]    wr_frame_r;
  logic [15:0]   rdata_r;
  logic [15:0]   mem [256];

  logic          wrap_s;
  logic          rise_s;
  logic          fall_s;
  logic [15:0]   shift_next_s;
  logic          we_s;
  logic [7:0]    waddr_s;
  logic [15:0]   wdata_s;

  // Strobes, next shift value and RAM write-port selection
  always_comb begin
    wrap_s       = (presc_r == PRESC_LAST);
    rise_s       = wrap_s & ~sck_r;
    fall_s       = wrap_s & sck_r;
    shift_next_s = {shift_r[14:0], bus.sd};
    // The right half of a pair always follows the left half on the next cycle.
    if (right_pend_r) begin
      we_s    = 1'b1;
      waddr_s = {wr_frame_r, 1'b1};
      wdata_s = right_r;
    end else if (sample_valid_r && bus.capture_en) begin
      we_s    = 1'b1;
      waddr_s = {frame_r[6:0], 1'b0};
      wdata_s = left_r;
    end else begin
      we_s    = 1'b0;
      waddr_s = {frame_r[6:0], 1'b0};
      wdata_s = left_r;
    end
  end

  // Bit-clock prescaler, frame position and frame counter
  always_ff @(posedge ck) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
      sck_r   <= 1'b0;
      posn_r  <= 6'd0;
      frame_r <= 8'd0;
    end else begin
      if (wrap_s) begin
        presc_r <= {PW{1'b0}};
        sck_r   <= ~sck_r;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      // Position moves on the falling edge so it is stable when data is sampled.
      if (fall_s) begin
        posn_r <= posn_r + 6'd1;
        if (posn_r == 6'd63) begin
          frame_r <= frame_r + 8'd1;
        end
      end
    end
  end

  // Serial shift register and sample capture
  always_ff @(posedge ck) begin
    if (rst) begin
      shift_r        <= 16'h0000;
      left_r         <= 16'h0000;
      right_r        <= 16'h0000;
      right_done_r   <= 1'b0;
      sample_valid_r <= 1'b0;
    end else begin
      right_done_r   <= rise_s && (posn_r == RIGHT_DONE);
      sample_valid_r <= right_done_r;
      if (rise_s) begin
        shift_r <= shift_next_s;
        if (posn_r == LEFT_DONE) begin
          left_r <= shift_next_s;
        end
        if (posn_r == RIGHT_DONE) begin
          right_r <= shift_next_s;
        end
      end
    end
  end

  // Pending right-sample write and the frame it belongs to
  always_ff @(posedge ck) begin
    if (rst) begin
      right_pend_r <= 1'b0;
      wr_frame_r   <= 7'd0;
    end else begin
      right_pend_r <= sample_valid_r && bus.capture_en;
      if (sample_valid_r && bus.capture_en) begin
        wr_frame_r <= frame_r[6:0];
      end
    end
  end

  // Sample RAM write port; contents survive reset
  always_ff @(posedge ck) begin
    if (we_s && !rst) begin
      mem[waddr_s] <= wdata_s;
    end
  end

  // Registered host read port: same-address write returns the old word
  always_ff @(posedge ck) begin
    if (rst) begin
      rdata_r <= 16'h0000;
    end else if (bus.re) begin
      rdata_r <= mem[bus.raddr];
    end
  end

  assign bus.sck          = sck_r;
  assign bus.ws           = posn_r[5];
  assign bus.frame_posn   = posn_r;
  assign bus.frame        = frame_r;
  assign bus.left         = left_r;
  assign bus.right        = right_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.rdata        = rdata_r;
endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: sck-clocked transmitter model, arithmetic timing model,
// word-array sample model and a RAM scoreboard, plus directed corner sequences.
module tb_i2s_rx_capture;
  localparam int SCK_DIV  = 2;
  localparam int FRAME_CK = 128 * SCK_DIV;
  localparam int SV_OFS   = 97 * SCK_DIV + 1;
  localparam int RST_N    = 10 * FRAME_CK + 20 * 2 * SCK_DIV + 1;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  i2s_rx_capture_if bus();
  i2s_rx_capture #(.SCK_DIV(SCK_DIV)) dut (.ck(ck), .rst(rst), .bus(bus.slave));

  always #5 ck = ~ck;

  typedef struct {
    int         n;
    logic       sck;
    logic [5:0] posn;
    logic       ws;
    logic [7:0] frame;
  } tvec_t;

  tvec_t       tv [12];
  logic [15:0] exp_left [3];
  logic [15:0] exp_right [3];
  logic [15:0] exp_ram [6];
  logic [31:0] lw [16];
  logic [31:0] rw [16];
  logic [15:0] ram_model [256];
  bit          ram_valid [256];
  logic [15:0] rd_exp = 16'h0000;
  bit          rd_ok  = 1'b0;
  bit          rpend  = 1'b0;
  logic [6:0]  rbase  = 7'd0;
  int          mf;
  int          n      = 0;
  int          checks = 0;
  int          errors = 0;
  int          tx_pos = 0;
  int          tx_frm = 0;
  bit          mon_on = 1'b0;

  // Frame f's pair completes one cycle after the sck rise at position 48.
  function automatic bit is_sv(input int cnt);
    return (cnt >= SV_OFS) && (((cnt - SV_OFS) % FRAME_CK) == 0);
  endfunction

  // Transmitter: shifts a new bit out after each sck fall, MSB one slot after ws changes
  always @(negedge bus.sck or posedge rst) begin
    if (rst) begin
      tx_pos = 0;
      tx_frm = 0;
      bus.sd = 1'b0;
    end else begin
      tx_pos = (tx_pos + 1) % 64;
      if (tx_pos == 0) tx_frm = tx_frm + 1;
      #1;
      if (tx_pos >= 1 && tx_pos <= 32) bus.sd = lw[tx_frm % 16][32 - tx_pos];
      else if (tx_pos >= 33)           bus.sd = rw[tx_frm % 16][64 - tx_pos];
      else                             bus.sd = 1'b0;
    end
  end

  // Cycle counter, RAM scoreboard and expected read data
  always @(posedge ck) begin
    if (rst) begin
      n      <= 0;
      rd_exp <= 16'h0000;
      rd_ok  <= 1'b1;
      rpend  <= 1'b0;
    end else begin
      n <= n + 1;
      if (bus.re) begin
        rd_exp <= ram_model[bus.raddr];
        rd_ok  <= ram_valid[bus.raddr];
      end
      rpend <= 1'b0;
      if (is_sv(n) && bus.capture_en) begin
        mf = n / FRAME_CK;
        ram_model[{mf[6:0], 1'b0}] <= lw[mf % 16][31:16];
        ram_valid[{mf[6:0], 1'b0}] <= 1'b1;
        rpend <= 1'b1;
        rbase <= mf[6:0];
      end
      if (rpend) begin
        ram_model[{rbase, 1'b1}] <= rw[rbase[3:0]][31:16];
        ram_valid[{rbase, 1'b1}] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic tick();
    int f;
    @(negedge ck);
    if (mon_on) begin
      f = n / FRAME_CK;
      chk("sample_valid", {31'd0, bus.sample_valid}, {31'd0, is_sv(n)});
      if (is_sv(n)) begin
        chk("left_model", {16'd0, bus.left}, {16'd0, lw[f % 16][31:16]});
        chk("right_model", {16'd0, bus.right}, {16'd0, rw[f % 16][31:16]});
        chk("posn_at_valid", {26'd0, bus.frame_posn}, 32'd48);
        chk("frame_at_valid", {24'd0, bus.frame}, f % 256);
      end
      if (rd_ok) chk("rdata_model", {16'd0, bus.rdata}, {16'd0, rd_exp});
    end
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (n != target && guard < 5000) begin
      tick();
      guard++;
    end
    if (n != target) chk("run_to_timeout", n, target);
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
    bus.re    = 1'b1;
    bus.raddr = a;
    tick();
    chk(name, {16'd0, bus.rdata}, {16'd0, exp});
    bus.re = 1'b0;
  endtask

  task automatic fill_words(input bit ramp);
    for (int f = 0; f < 16; f++) begin
      if (ramp && f < 3) begin
        lw[f] = 32'h8234_0000 + 32'(f) * 32'h0002_0000;
        rw[f] = 32'h1234_0000 + 32'(f) * 32'h0010_0000;
      end else begin
        lw[f] = $urandom;
        rw[f] = $urandom;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sck"},   {31'd0, bus.sck}, 32'd0);
    chk({tag, "_ws"},    {31'd0, bus.ws}, 32'd0);
    chk({tag, "_posn"},  {26'd0, bus.frame_posn}, 32'd0);
    chk({tag, "_frame"}, {24'd0, bus.frame}, 32'd0);
    chk({tag, "_left"},  {16'd0, bus.left}, 32'd0);
    chk({tag, "_right"}, {16'd0, bus.right}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.sample_valid}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, bus.rdata}, 32'd0);
  endtask

  initial begin
    int ti;
    tv[0]  = '{0,   1'b0, 6'd0,  1'b0, 8'd0};
    tv[1]  = '{1,   1'b0, 6'd0,  1'b0, 8'd0};
    tv[2]  = '{2,   1'b1, 6'd0,  1'b0, 8'd0};
    tv[3]  = '{4,   1'b0, 6'd1,  1'b0, 8'd0};
    tv[4]  = '{124, 1'b0, 6'd31, 1'b0, 8'd0};
    tv[5]  = '{128, 1'b0, 6'd32, 1'b1, 8'd0};
    tv[6]  = '{130, 1'b1, 6'd32, 1'b1, 8'd0};
    tv[7]  = '{255, 1'b1, 6'd63, 1'b1, 8'd0};
    tv[8]  = '{256, 1'b0, 6'd0,  1'b0, 8'd1};
    tv[9]  = '{512, 1'b0, 6'd0,  1'b0, 8'd2};
    tv[10] = '{767, 1'b1, 6'd63, 1'b1, 8'd2};
    tv[11] = '{768, 1'b0, 6'd0,  1'b0, 8'd3};
    exp_left  = '{16'h8234, 16'h8236, 16'h8238};
    exp_right = '{16'h1234, 16'h1244, 16'h1254};
    exp_ram   = '{16'h8234, 16'h1234, 16'h8236, 16'h1244, 16'h8238, 16'h1254};

    bus.re = 1'b0;
    bus.raddr = 8'd0;
    bus.capture_en = 1'b0;
    rst = 1'b1;
    fill_words(1'b1);
    repeat (3) tick();
    chk_all_zero("reset");

    mon_on = 1'b1;
    bus.capture_en = 1'b1;
    rst = 1'b0;
    ti = 0;
    for (int c = 0; c < 1000 && n < 900; c++) begin
      if (ti < 12 && n == tv[ti].n) begin
        chk("tm_sck",   {31'd0, bus.sck}, {31'd0, tv[ti].sck});
        chk("tm_posn",  {26'd0, bus.frame_posn}, {26'd0, tv[ti].posn});
        chk("tm_ws",    {31'd0, bus.ws}, {31'd0, tv[ti].ws});
        chk("tm_frame", {24'd0, bus.frame}, {24'd0, tv[ti].frame});
        ti++;
      end
      for (int f = 0; f < 3; f++) begin
        if (n == SV_OFS + f * FRAME_CK) begin
          chk("ramp_left",  {16'd0, bus.left},  {16'd0, exp_left[f]});
          chk("ramp_right", {16'd0, bus.right}, {16'd0, exp_right[f]});
        end
      end
      tick();
    end
    chk("timing_table_done", ti, 32'd12);

    bus.capture_en = 1'b0;
    for (int a = 0; a < 6; a++) read_chk("ram_read", 8'(a), exp_ram[a]);

    for (int c = 0; c < 3000; c++) begin
      if (n == RST_N) break;
      if (n % FRAME_CK == 10) bus.capture_en = 1'($urandom_range(0, 1));
      bus.re    = 1'($urandom_range(0, 1));
      bus.raddr = 8'($urandom_range(0, 23));
      tick();
    end
    bus.re = 1'b0;
    chk("posn_before_rst",  {26'd0, bus.frame_posn}, 32'd20);
    chk("frame_before_rst", {24'd0, bus.frame}, 32'd10);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    fill_words(1'b0);
    if (lw[0][31:16] == 16'h8234) lw[0][31:16] = 16'h7234;
    if (rw[0][31:16] == 16'h1234) rw[0][31:16] = 16'h0234;
    tick();
    bus.capture_en = 1'b1;
    rst = 1'b0;
    for (int a = 0; a < 6; a++) read_chk("ram_kept", 8'(a), exp_ram[a]);

    run_to(SV_OFS);
    bus.re = 1'b1;
    bus.raddr = 8'd0;
    tick();
    chk("coll_left_old", {16'd0, bus.rdata}, 32'h8234);
    bus.raddr = 8'd1;
    tick();
    chk("coll_right_old", {16'd0, bus.rdata}, 32'h1234);
    bus.raddr = 8'd0;
    tick();
    chk("coll_left_new", {16'd0, bus.rdata}, {16'd0, lw[0][31:16]});
    bus.raddr = 8'd1;
    tick();
    chk("coll_right_new", {16'd0, bus.rdata}, {16'd0, rw[0][31:16]});
    bus.re = 1'b0;
    bus.capture_en = 1'b0;

    run_to(SV_OFS + FRAME_CK + 5);
    read_chk("no_capture_l", 8'd2, 16'h8236);
    read_chk("no_capture_r", 8'd3, 16'h1244);
    bus.capture_en = 1'b1;
    for (int c = 0; c < 1000 && n < 800; c++) begin
      bus.re    = 1'($urandom_range(0, 1));
      bus.raddr = 8'($urandom_range(0, 23));
      tick();
    end
    bus.re = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
